// File: rtl/red_pitaya_droplet_gen_if.sv
// System-bus bundle for the droplet generator register map.
// The bus master drives address, data and strobes; the generator returns read data and ack.
interface red_pitaya_droplet_gen_if;
    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic [3:0]  sys_sel;
    logic        sys_wen;
    logic        sys_ren;
    logic [31:0] sys_rdata;
    logic        sys_err;
    logic        sys_ack;

    modport master (
        output sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
        input  sys_rdata, sys_err, sys_ack
    );

    modport slave (
        input  sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
        output sys_rdata, sys_err, sys_ack
    );
endinterface

// File: rtl/red_pitaya_droplet_gen.sv
// Synthetic trapezoid droplet pulse generator with sort-trigger counting and latency capture.
// Optional amplitude jitter from a 16-bit LFSR is built when DROPLET_GEN_LFSR_EN is defined.
module red_pitaya_droplet_gen #(
    parameter int DWT = 14,
    parameter int MEM = 32
) (
    input  logic                  adc_clk_i,
    input  logic                  adc_rst_i,
    input  logic                  sort_trig_i,
    output logic signed [DWT-1:0] dac_o,
    output logic                  pulse_o,
    output logic [7:0]            debug,
    red_pitaya_droplet_gen_if.slave sys
);
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0, ST_GAP = 3'd1, ST_RISE = 3'd2,
        ST_PLAT = 3'd3, ST_FALL = 3'd4, ST_DONE = 3'd5
    } state_t;

    localparam logic [MEM-1:0] ZERO_M = {MEM{1'b0}};
    localparam logic [MEM-1:0] ONE_M  = {{(MEM-1){1'b0}}, 1'b1};
    localparam logic [MEM-1:0] MAX_M  = {MEM{1'b1}};
    localparam logic signed [DWT+1:0] SAT_HI = {3'b000, {(DWT-1){1'b1}}};
    localparam logic signed [DWT+1:0] SAT_LO = {3'b111, {(DWT-1){1'b0}}};

    // Clamp a guard-bit result back into the signed DAC range.
    function automatic logic signed [DWT-1:0] sat_f(input logic signed [DWT+1:0] v);
        if (v > SAT_HI) begin
            return SAT_HI[DWT-1:0];
        end else if (v < SAT_LO) begin
            return SAT_LO[DWT-1:0];
        end else begin
            return v[DWT-1:0];
        end
    endfunction

    logic                  enable_r;
    logic signed [DWT-1:0] base_r, amp_r, base_sh_r, amp_sh_r, out_r;
    logic [DWT-1:0]        step_r, step_sh_r;
    logic [MEM-1:0]        width_r, gap_r, burst_r, width_sh_r, cnt_r, bcnt_r;
    logic [MEM-1:0]        emitted_r, trig_cnt_r, last_lat_r, lat_r;
    logic                  armed_r, trig_q_r, trig_d_r, pulse_r, ack_r;
    logic [7:0]            debug_r;
    logic [31:0]           rdata_r, rd_mux_s;
    state_t                state_r, state_n_s;
    logic signed [DWT-1:0] out_n_s, eff_amp_s, rise_sum_s, fall_dif_s;
    logic [MEM-1:0]        cnt_n_s, bcnt_n_s;
    logic                  latch_s, fall_end_s, abort_s, clr_s, trig_rise_s;
    logic                  gap_done_s, width_done_s, unused_s;

    assign clr_s       = sys.sys_wen && (sys.sys_addr[19:0] == 20'h00000) && sys.sys_wdata[1];
    assign trig_rise_s = trig_q_r && !trig_d_r;
    assign abort_s     = !enable_r && (state_r != ST_DONE);
    assign gap_done_s  = (gap_r == ZERO_M) || (cnt_r >= gap_r - ONE_M);
    assign width_done_s = (width_sh_r == ZERO_M) || (cnt_r >= width_sh_r - ONE_M);
    // Two guard bits: the step is unsigned full-width, so out +/- step can exceed one extra bit.
    assign rise_sum_s  = sat_f($signed({{2{out_r[DWT-1]}}, out_r}) + $signed({2'b00, step_sh_r}));
    assign fall_dif_s  = sat_f($signed({{2{out_r[DWT-1]}}, out_r}) - $signed({2'b00, step_sh_r}));

`ifdef DROPLET_GEN_LFSR_EN
    logic [15:0]    lfsr_r;
    logic [DWT-1:0] jit_r;

    // Galois form, taps 16,14,13,11.
    function automatic logic [15:0] lfsr_next_f(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    assign eff_amp_s = sat_f($signed({{2{amp_r[DWT-1]}}, amp_r}) - $signed({2'b00, lfsr_r[DWT-1:0] & jit_r}));
    assign unused_s  = ^{sys.sys_sel, sys.sys_addr[31:20], lfsr_r[15:DWT]};

    // Jitter source advances once per droplet start; mask is bus-written.
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            lfsr_r <= 16'hACE1;
            jit_r  <= {DWT{1'b0}};
        end else begin
            if (latch_s) lfsr_r <= lfsr_next_f(lfsr_r);
            if (sys.sys_wen && (sys.sys_addr[19:0] == 20'h0001C)) jit_r <= sys.sys_wdata[DWT-1:0];
        end
    end
`else
    assign eff_amp_s = amp_r;
    assign unused_s  = ^{sys.sys_sel, sys.sys_addr[31:20]};
`endif

    // Next-state and next-sample logic for the trapezoid sequencer.
    always_comb begin
        state_n_s  = state_r;
        out_n_s    = out_r;
        cnt_n_s    = cnt_r;
        bcnt_n_s   = bcnt_r;
        latch_s    = 1'b0;
        fall_end_s = 1'b0;
        if (abort_s) begin
            state_n_s = ST_IDLE;
            out_n_s   = base_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    out_n_s = base_r;
                    if (enable_r) begin
                        state_n_s = ST_GAP;
                        cnt_n_s   = ZERO_M;
                        bcnt_n_s  = ZERO_M;
                    end else begin
                        state_n_s = ST_IDLE;
                    end
                end
                ST_GAP: begin
                    out_n_s = base_r;
                    if (gap_done_s) begin
                        state_n_s = ST_RISE;
                        latch_s   = 1'b1;
                    end else begin
                        cnt_n_s = cnt_r + ONE_M;
                    end
                end
                ST_RISE: begin
                    if ((step_sh_r == {DWT{1'b0}}) || (rise_sum_s >= amp_sh_r)) begin
                        out_n_s   = amp_sh_r;
                        state_n_s = ST_PLAT;
                        cnt_n_s   = ZERO_M;
                    end else begin
                        out_n_s = rise_sum_s;
                    end
                end
                ST_PLAT: begin
                    if (width_done_s) begin
                        state_n_s = ST_FALL;
                    end else begin
                        cnt_n_s = cnt_r + ONE_M;
                    end
                end
                ST_FALL: begin
                    if ((step_sh_r == {DWT{1'b0}}) || (fall_dif_s <= base_sh_r)) begin
                        out_n_s    = base_sh_r;
                        fall_end_s = 1'b1;
                        bcnt_n_s   = bcnt_r + ONE_M;
                        cnt_n_s    = ZERO_M;
                        if ((burst_r != ZERO_M) && (bcnt_r + ONE_M == burst_r)) begin
                            state_n_s = ST_DONE;
                        end else begin
                            state_n_s = ST_GAP;
                        end
                    end else begin
                        out_n_s = fall_dif_s;
                    end
                end
                ST_DONE: begin
                    out_n_s = base_r;
                    if (!enable_r) begin
                        state_n_s = ST_IDLE;
                    end else begin
                        state_n_s = ST_DONE;
                    end
                end
                default: begin
                    state_n_s = ST_IDLE;
                    out_n_s   = base_r;
                end
            endcase
        end
    end

    // Sequencer state, sample, and registered status outputs.
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            state_r <= ST_IDLE;
            out_r   <= {DWT{1'b0}};
            cnt_r   <= ZERO_M;
            bcnt_r  <= ZERO_M;
            pulse_r <= 1'b0;
            debug_r <= 8'h01;
        end else begin
            state_r <= state_n_s;
            out_r   <= out_n_s;
            cnt_r   <= cnt_n_s;
            bcnt_r  <= bcnt_n_s;
            pulse_r <= (state_n_s == ST_RISE) || (state_n_s == ST_PLAT) || (state_n_s == ST_FALL);
            debug_r <= 8'h01 << state_n_s;
        end
    end

    // Per-droplet shadow copies so mid-pulse writes only affect the next droplet.
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            base_sh_r  <= {DWT{1'b0}};
            amp_sh_r   <= 14'sd1000;
            step_sh_r  <= {DWT{1'b0}};
            width_sh_r <= 32'd1250;
        end else if (latch_s) begin
            base_sh_r  <= base_r;
            amp_sh_r   <= eff_amp_s;
            step_sh_r  <= step_r;
            width_sh_r <= width_r;
        end
    end

    // Sort-trigger edge counting and droplet-end to trigger latency capture.
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            trig_q_r   <= 1'b0;
            trig_d_r   <= 1'b0;
            lat_r      <= ZERO_M;
            armed_r    <= 1'b0;
            emitted_r  <= ZERO_M;
            trig_cnt_r <= ZERO_M;
            last_lat_r <= ZERO_M;
        end else begin
            trig_q_r <= sort_trig_i;
            trig_d_r <= trig_q_r;
            if (fall_end_s) lat_r <= ZERO_M;
            else if (lat_r != MAX_M) lat_r <= lat_r + ONE_M;
            if (fall_end_s) armed_r <= 1'b1;
            else if (trig_rise_s) armed_r <= 1'b0;
            if (clr_s) emitted_r <= ZERO_M;
            else if (fall_end_s) emitted_r <= emitted_r + ONE_M;
            if (clr_s) trig_cnt_r <= ZERO_M;
            else if (trig_rise_s) trig_cnt_r <= trig_cnt_r + ONE_M;
            if (clr_s) last_lat_r <= ZERO_M;
            else if (trig_rise_s && armed_r) last_lat_r <= lat_r;
        end
    end

    // Register read decode; unmapped addresses return zero.
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        case (sys.sys_addr[19:0])
            20'h00000: rd_mux_s = {31'd0, enable_r};
            20'h00004: rd_mux_s = {{(32-DWT){1'b0}}, base_r};
            20'h00008: rd_mux_s = {{(32-DWT){1'b0}}, amp_r};
            20'h0000C: rd_mux_s = {{(32-DWT){1'b0}}, step_r};
            20'h00010: rd_mux_s = 32'(width_r);
            20'h00014: rd_mux_s = 32'(gap_r);
            20'h00018: rd_mux_s = 32'(burst_r);
`ifdef DROPLET_GEN_LFSR_EN
            20'h0001C: rd_mux_s = {{(32-DWT){1'b0}}, jit_r};
`endif
            20'h00100: rd_mux_s = 32'(emitted_r);
            20'h00104: rd_mux_s = 32'(trig_cnt_r);
            20'h00108: rd_mux_s = 32'(last_lat_r);
            20'h0010C: rd_mux_s = {29'd0, state_r};
            default:   rd_mux_s = 32'h0000_0000;
        endcase
    end

    // Bus register writes, read data and single-cycle ack.
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            enable_r <= 1'b0;
            base_r   <= {DWT{1'b0}};
            amp_r    <= 14'sd1000;
            step_r   <= {DWT{1'b0}};
            width_r  <= 32'd1250;
            gap_r    <= 32'd12500;
            burst_r  <= ZERO_M;
            ack_r    <= 1'b0;
            rdata_r  <= 32'h0000_0000;
        end else begin
            ack_r <= sys.sys_wen || sys.sys_ren;
            if (sys.sys_ren) rdata_r <= rd_mux_s;
            if (sys.sys_wen) begin
                case (sys.sys_addr[19:0])
                    20'h00000: enable_r <= sys.sys_wdata[0];
                    20'h00004: base_r   <= sys.sys_wdata[DWT-1:0];
                    20'h00008: amp_r    <= sys.sys_wdata[DWT-1:0];
                    20'h0000C: step_r   <= sys.sys_wdata[DWT-1:0];
                    20'h00010: width_r  <= MEM'(sys.sys_wdata);
                    20'h00014: gap_r    <= MEM'(sys.sys_wdata);
                    20'h00018: burst_r  <= MEM'(sys.sys_wdata);
                    default:   ;
                endcase
            end
        end
    end

    assign dac_o         = out_r;
    assign pulse_o       = pulse_r;
    assign debug         = debug_r;
    assign sys.sys_rdata = rdata_r;
    assign sys.sys_ack   = ack_r;
    assign sys.sys_err   = 1'b0;
endmodule

// File: tb/tb_red_pitaya_droplet_gen.sv
// Scoreboard bench for red_pitaya_droplet_gen: expected DAC traces and register reads are
// queued when stimulus is issued and popped as the generator produces them.
module tb_red_pitaya_droplet_gen;
    localparam logic [31:0] A_CTRL = 32'h000, A_BASE = 32'h004, A_AMP = 32'h008, A_STEP = 32'h00C;
    localparam logic [31:0] A_WIDTH = 32'h010, A_GAP = 32'h014, A_BURST = 32'h018, A_JIT = 32'h01C;
    localparam logic [31:0] A_EMIT = 32'h100, A_TRIG = 32'h104, A_LAT = 32'h108, A_STATE = 32'h10C;

    logic               clk = 1'b0;
    logic               rst;
    logic               trig;
    logic signed [13:0] dac_o;
    logic               pulse_o;
    logic [7:0]         debug;
    int                 n_checks = 0;
    int                 n_errors = 0;
    int                 exp_q[$];
    int                 rd_q[$];

    red_pitaya_droplet_gen_if sys ();

    red_pitaya_droplet_gen dut (
        .adc_clk_i   (clk),
        .adc_rst_i   (rst),
        .sort_trig_i (trig),
        .dac_o       (dac_o),
        .pulse_o     (pulse_o),
        .debug       (debug),
        .sys         (sys)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        sys.sys_addr  = a;
        sys.sys_wdata = d;
        sys.sys_wen   = 1'b1;
        @(negedge clk);
        sys.sys_wen   = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, input int exp, input string tag);
        rd_q.push_back(exp);
        @(negedge clk);
        sys.sys_addr = a;
        sys.sys_ren  = 1'b1;
        @(negedge clk);
        sys.sys_ren  = 1'b0;
        check_eq({tag, "_ack"}, int'(sys.sys_ack), 1);
        check_eq(tag, int'(sys.sys_rdata), rd_q.pop_front());
    endtask

    task automatic wait_pulse(input logic lvl, input string tag, output int n);
        n = 0;
        while (pulse_o !== lvl && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_pulse"}, int'(pulse_o), int'(lvl));
    endtask

    // Waits for the pulse to start, then compares one queued sample per cycle.
    task automatic run_pulse(input string tag, output int n);
        wait_pulse(1'b1, tag, n);
        if (pulse_o !== 1'b1) begin
            exp_q.delete();
        end else begin
            while (exp_q.size() > 0) begin
                check_eq(tag, int'($signed(dac_o)), exp_q.pop_front());
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t2_trace[11] = '{-100, -36, 28, 92, 100, 100, 100, 36, -28, -92, -100};
        rst = 1'b1;
        trig = 1'b0;
        sys.sys_addr = 32'h0;
        sys.sys_wdata = 32'h0;
        sys.sys_sel = 4'hF;
        sys.sys_wen = 1'b0;
        sys.sys_ren = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_dac", int'($signed(dac_o)), 0);
        check_eq("rst_pulse", int'(pulse_o), 0);
        check_eq("rst_debug", int'(debug), 32'h01);
        check_eq("rst_ack", int'(sys.sys_ack), 0);
        rst = 1'b0;
        bus_rd(A_CTRL, 0, "def_ctrl");
        bus_rd(A_AMP, 1000, "def_amp");
        bus_rd(A_WIDTH, 1250, "def_width");
        bus_rd(A_GAP, 12500, "def_gap");
        bus_rd(A_BURST, 0, "def_burst");
        bus_rd(A_STATE, 0, "def_state");
        check_eq("sys_err", int'(sys.sys_err), 0);

        // Single droplet, step 0: 2 gap cycles, 1 RISE, 4-cycle plateau, FALL, DONE.
        bus_wr(A_WIDTH, 32'd4);
        bus_wr(A_GAP, 32'd2);
        bus_wr(A_AMP, 32'd500);
        bus_wr(A_BURST, 32'd1);
        exp_q = '{0, 500, 500, 500, 500, 500, 0};
        bus_wr(A_CTRL, 32'd1);
        run_pulse("t1_trace", n);
        check_eq("t1_gap_len", n, 1 + 2);
        check_eq("t1_debug_done", int'(debug), 32'h20);
        bus_rd(A_STATE, 5, "t1_state");
        bus_rd(A_EMIT, 1, "t1_emitted");

        // Negative baseline with a stepped ramp.
        bus_wr(A_CTRL, 32'd0);
        bus_wr(A_CTRL, 32'd2);
        bus_wr(A_BASE, 32'hFFFF_FF9C);
        bus_wr(A_AMP, 32'd100);
        bus_wr(A_STEP, 32'd64);
        bus_wr(A_WIDTH, 32'd2);
        bus_wr(A_GAP, 32'd1);
        bus_rd(A_BASE, 32'h0000_3F9C, "t2_base_rd");
        bus_rd(A_EMIT, 0, "t2_cleared");
        for (int i = 0; i < 11; i++) exp_q.push_back(t2_trace[i]);
        bus_wr(A_CTRL, 32'd1);
        run_pulse("t2_trace", n);
        bus_rd(A_EMIT, 1, "t2_emitted");

        // Continuous mode, aborted mid-plateau.
        bus_wr(A_CTRL, 32'd2);
        bus_wr(A_BASE, 32'd0);
        bus_wr(A_AMP, 32'd300);
        bus_wr(A_STEP, 32'd0);
        bus_wr(A_WIDTH, 32'd4);
        bus_wr(A_GAP, 32'd2);
        bus_wr(A_BURST, 32'd0);
        bus_wr(A_CTRL, 32'd1);
        for (int i = 0; i < 3; i++) begin
            wait_pulse(1'b1, "t3_hi", n);
            wait_pulse(1'b0, "t3_lo", n);
        end
        wait_pulse(1'b1, "t3_hi4", n);
        bus_wr(A_CTRL, 32'd0);
        check_eq("t3_mid_plateau", int'($signed(dac_o)), 300);
        @(negedge clk);
        check_eq("t3_abort_dac", int'($signed(dac_o)), 0);
        check_eq("t3_abort_pulse", int'(pulse_o), 0);
        check_eq("t3_abort_debug", int'(debug), 32'h01);
        bus_rd(A_EMIT, 3, "t3_emitted");

        // Trigger latency: first edge sampled 7 clocks after droplet end, second edge counted only.
        bus_wr(A_CTRL, 32'd2);
        bus_wr(A_AMP, 32'd200);
        bus_wr(A_WIDTH, 32'd2);
        bus_wr(A_BURST, 32'd1);
        bus_wr(A_CTRL, 32'd1);
        wait_pulse(1'b1, "t4_hi", n);
        wait_pulse(1'b0, "t4_lo", n);
        repeat (6) @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        repeat (5) @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        repeat (3) @(negedge clk);
        bus_rd(A_TRIG, 2, "t4_trig_cnt");
        bus_rd(A_LAT, 7, "t4_latency");
        bus_rd(A_EMIT, 1, "t4_emitted");
        bus_wr(A_CTRL, 32'd2);
        bus_rd(A_TRIG, 0, "t4_clr_trig");
        bus_rd(A_LAT, 0, "t4_clr_lat");
        bus_rd(A_EMIT, 0, "t4_clr_emit");

        // Amplitude write mid-plateau only affects the following droplet.
        bus_wr(A_AMP, 32'd1000);
        bus_wr(A_WIDTH, 32'd6);
        bus_wr(A_GAP, 32'd3);
        bus_wr(A_BURST, 32'd2);
        exp_q = '{0, 1000, 1000, 1000, 1000, 1000, 1000, 1000, 0};
        bus_wr(A_CTRL, 32'd1);
        fork
            run_pulse("t5_p1", n);
            begin
                int m;
                wait_pulse(1'b1, "t5_sync", m);
                repeat (2) @(negedge clk);
                bus_wr(A_AMP, 32'd2000);
            end
        join
        exp_q = '{0, 2000, 2000, 2000, 2000, 2000, 2000, 2000, 0};
        run_pulse("t5_p2", n);
        bus_rd(A_EMIT, 2, "t5_emitted");
        bus_rd(A_STATE, 5, "t5_state");

        // Saturation at the top of the signed range.
        bus_wr(A_CTRL, 32'd0);
        bus_wr(A_BASE, 32'd8000);
        bus_wr(A_AMP, 32'd8191);
        bus_wr(A_STEP, 32'd8000);
        bus_wr(A_WIDTH, 32'd1);
        bus_wr(A_GAP, 32'd1);
        bus_wr(A_BURST, 32'd1);
        exp_q = '{8000, 8191, 8191, 8000};
        bus_wr(A_CTRL, 32'd1);
        run_pulse("t6_trace", n);
        bus_rd(A_JIT, 0, "t6_jitter_mask");
        bus_rd(32'h200, 0, "unmapped");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
